// File: rtl/rs485_poll_master.sv
// Bus-master end of the RS485 9-bit multidrop link: sends an address frame,
// then collects a two-frame 16-bit response (low byte first) from the polled slave.
module rs485_poll_master #(
    parameter int CLKS_PER_BIT = 50,
    parameter int TIMEOUT_BITS = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  slave_addr,
    input  logic        Rx,
    output logic        Tx,
    output logic        Tx_Enable,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_BITS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_TX_ADDR    = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_RX_START   = 3'd3;
    localparam logic [2:0] S_RX_BITS    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    logic [2:0]             state_reg,       state_next;
    logic [CNT_W-1:0]       clk_cnt_reg,     clk_cnt_next;
    logic [3:0]             bit_idx_reg,     bit_idx_next;
    logic [TMO_W-1:0]       tmo_cnt_reg,     tmo_cnt_next;
    logic                   byte_idx_reg,    byte_idx_next;
    logic [10:0]            tx_shift_reg,    tx_shift_next;
    logic [7:0]             rx_shift_reg,    rx_shift_next;
    logic [7:0]             low_byte_reg,    low_byte_next;
    logic [15:0]            data_out_reg,    data_out_next;
    logic                   tx_reg,          tx_next;
    logic                   tx_en_reg,       tx_en_next;
    logic                   busy_reg,        busy_next;
    logic                   data_valid_reg,  data_valid_next;
    logic                   frame_err_reg,   frame_err_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic                   wait_entry_reg,  wait_entry_next;

    logic [SYNC_STAGES-1:0] rx_sync_reg, rx_sync_next;
    logic                   rx_prev_reg;
    logic                   rx_fall_d_reg;
    logic                   rx_s;
    logic                   rx_fall;
    logic                   start_seen;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign rx_sync_next[gi] = Rx;
            end else begin : g_chain
                assign rx_sync_next[gi] = rx_sync_reg[gi-1];
            end
        end
    endgenerate

    assign rx_s    = rx_sync_reg[SYNC_STAGES-1];
    assign rx_fall = rx_prev_reg & ~rx_s;
    // An edge landing on the very cycle WAIT_START is entered would otherwise be lost.
    assign start_seen = rx_fall | (wait_entry_reg & rx_fall_d_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_reg   <= '1;
            rx_prev_reg   <= 1'b1;
            rx_fall_d_reg <= 1'b0;
        end else begin
            rx_sync_reg   <= rx_sync_next;
            rx_prev_reg   <= rx_s;
            rx_fall_d_reg <= rx_fall;
        end
    end

    always_comb begin
        state_next       = state_reg;
        clk_cnt_next     = clk_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        byte_idx_next    = byte_idx_reg;
        tx_shift_next    = tx_shift_reg;
        rx_shift_next    = rx_shift_reg;
        low_byte_next    = low_byte_reg;
        data_out_next    = data_out_reg;
        tx_next          = tx_reg;
        tx_en_next       = tx_en_reg;
        busy_next        = busy_reg;
        data_valid_next  = 1'b0;
        frame_err_next   = 1'b0;
        timeout_err_next = 1'b0;
        wait_entry_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    // Frame image LSB first: start, d0..d7, flag=1, stop.
                    tx_shift_next = {1'b1, 1'b1, slave_addr, 1'b0};
                    tx_next       = 1'b0;
                    tx_en_next    = 1'b1;
                    busy_next     = 1'b1;
                    clk_cnt_next  = '0;
                    bit_idx_next  = '0;
                    state_next    = S_TX_ADDR;
                end
            end

            S_TX_ADDR: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (bit_idx_reg == 4'd10) begin
                        tx_next         = 1'b1;
                        tx_en_next      = 1'b0;
                        byte_idx_next   = 1'b0;
                        tmo_cnt_next    = '0;
                        wait_entry_next = 1'b1;
                        state_next      = S_WAIT_START;
                    end else begin
                        bit_idx_next  = bit_idx_reg + 1'b1;
                        tx_next       = tx_shift_reg[1];
                        tx_shift_next = {1'b1, tx_shift_reg[10:1]};
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            S_WAIT_START: begin
                if (start_seen) begin
                    clk_cnt_next = '0;
                    state_next   = S_RX_START;
                end else if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (tmo_cnt_reg == TMO_LAST) begin
                        timeout_err_next = 1'b1;
                        busy_next        = 1'b0;
                        state_next       = S_IDLE;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            S_RX_START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    if (rx_s) begin
                        frame_err_next = 1'b1;
                        busy_next      = 1'b0;
                        state_next     = S_IDLE;
                    end else begin
                        bit_idx_next = '0;
                        state_next   = S_RX_BITS;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            S_RX_BITS: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg < 4'd8) begin
                        rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    end else if (bit_idx_reg == 4'd8) begin
                        // Data frames must carry flag=0.
                        if (rx_s) begin
                            frame_err_next = 1'b1;
                            busy_next      = 1'b0;
                            state_next     = S_IDLE;
                        end
                    end else begin
                        if (!rx_s) begin
                            frame_err_next = 1'b1;
                            busy_next      = 1'b0;
                            state_next     = S_IDLE;
                        end else if (!byte_idx_reg) begin
                            low_byte_next   = rx_shift_reg;
                            byte_idx_next   = 1'b1;
                            tmo_cnt_next    = '0;
                            wait_entry_next = 1'b1;
                            state_next      = S_WAIT_START;
                        end else begin
                            state_next = S_DONE;
                        end
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            S_DONE: begin
                data_out_next   = {rx_shift_reg, low_byte_reg};
                data_valid_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = S_IDLE;
            end

            default: begin
                tx_next    = 1'b1;
                tx_en_next = 1'b0;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            clk_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            tmo_cnt_reg     <= '0;
            byte_idx_reg    <= 1'b0;
            tx_shift_reg    <= '1;
            rx_shift_reg    <= '0;
            low_byte_reg    <= '0;
            data_out_reg    <= '0;
            tx_reg          <= 1'b1;
            tx_en_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            data_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            wait_entry_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            clk_cnt_reg     <= clk_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            byte_idx_reg    <= byte_idx_next;
            tx_shift_reg    <= tx_shift_next;
            rx_shift_reg    <= rx_shift_next;
            low_byte_reg    <= low_byte_next;
            data_out_reg    <= data_out_next;
            tx_reg          <= tx_next;
            tx_en_reg       <= tx_en_next;
            busy_reg        <= busy_next;
            data_valid_reg  <= data_valid_next;
            frame_err_reg   <= frame_err_next;
            timeout_err_reg <= timeout_err_next;
            wait_entry_reg  <= wait_entry_next;
        end
    end

    assign Tx          = tx_reg;
    assign Tx_Enable   = tx_en_reg;
    assign busy        = busy_reg;
    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign frame_err   = frame_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule
